// File: rtl/button_code_lock.sv
// button_code_lock: checks debounced button presses against a fixed combination and opens a timed unlock window.
// Define BUTTON_LOCK_LOCKOUT_EN to build the failure counter and the timed lockout after MAX_FAIL consecutive failures.
module button_code_lock #(
   parameter int          CODE_LEN    = 4,
   parameter logic [13:0] CODE        = 14'b10_00_01_10,
   parameter logic [23:0] OPEN_CYCLES = 24'd10_000_000,
   parameter int          MAX_FAIL    = 3,
   parameter logic [27:0] LOCK_CYCLES = 28'd100_000_000
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       b0,
   input  logic       b1,
   input  logic       b2,
   output logic       unlocked,
   output logic       error,
   output logic       lockout,
   output logic [2:0] progress
);
   localparam int CW = ($bits(OPEN_CYCLES) > $bits(LOCK_CYCLES)) ? $bits(OPEN_CYCLES) : $bits(LOCK_CYCLES);
   localparam logic [17:0] CODE_X = 18'(CODE);
   if (CODE_LEN < 1 || CODE_LEN > 7 || MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_param
      $error("button_code_lock: CODE_LEN and MAX_FAIL must be 1..7");
   end
   typedef enum logic [2:0] {IDLE, ENTRY, OPEN, FAIL, LOCK} state_t;
   state_t state, state_n;
   logic [2:0] progress_n;
   logic bad, bad_n, valid, miss, last;
   logic [1:0] sym;
   logic [CW-1:0] cnt, cnt_n;
`ifdef BUTTON_LOCK_LOCKOUT_EN
   localparam logic [2:0] MF = 3'(MAX_FAIL);
   logic [2:0] fails, fails_n;
`endif
   // two or three simultaneous pulses are not a press
   assign valid = (b0 ^ b1 ^ b2) & ~(b0 & b1 & b2);
   assign sym = b1 ? 2'd1 : b2 ? 2'd2 : 2'd0;
   assign miss = bad | (CODE_X[{progress, 1'b0} +: 2] != sym);
   assign last = progress == 3'(CODE_LEN - 1);
   always_comb begin
      state_n = state;
      progress_n = progress;
      bad_n = bad;
      cnt_n = cnt;
`ifdef BUTTON_LOCK_LOCKOUT_EN
      fails_n = fails;
`endif
      case (state)
         IDLE, ENTRY: if (valid) begin
            progress_n = last ? 3'd0 : progress + 3'd1;
            bad_n = last ? 1'b0 : miss;
            state_n = !last ? ENTRY : miss ? FAIL : OPEN;
            cnt_n = CW'(OPEN_CYCLES - 1'b1);
`ifdef BUTTON_LOCK_LOCKOUT_EN
            fails_n = (last && !miss) ? 3'd0 : fails;
`endif
         end
         OPEN: begin
            cnt_n = cnt - 1'b1;
            state_n = (cnt == '0) ? IDLE : OPEN;
         end
`ifdef BUTTON_LOCK_LOCKOUT_EN
         FAIL: begin
            fails_n = (fails == 3'd7) ? 3'd7 : fails + 3'd1;
            state_n = (fails_n >= MF) ? LOCK : IDLE;
            cnt_n = CW'(LOCK_CYCLES - 1'b1);
         end
         LOCK: begin
            cnt_n = cnt - 1'b1;
            state_n = (cnt == '0) ? IDLE : LOCK;
            fails_n = (cnt == '0) ? 3'd0 : fails;
         end
`endif
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state <= IDLE;
         progress <= '0;
         bad <= 1'b0;
         cnt <= '0;
`ifdef BUTTON_LOCK_LOCKOUT_EN
         fails <= '0;
`endif
      end else begin
         state <= state_n;
         progress <= progress_n;
         bad <= bad_n;
         cnt <= cnt_n;
`ifdef BUTTON_LOCK_LOCKOUT_EN
         fails <= fails_n;
`endif
      end
   end
   assign unlocked = state == OPEN;
   assign error = state == FAIL;
`ifdef BUTTON_LOCK_LOCKOUT_EN
   assign lockout = state == LOCK;
`else
   assign lockout = 1'b0;
`endif
endmodule

// File: tb/tb_button_code_lock.sv
// tb_button_code_lock: directed test-plan sequences plus random presses, checked every cycle against a behavioural model.
module tb_button_code_lock;
   logic sysclk = 1'b0;
   logic reset = 1'b1;
   logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;
   logic unlocked, error, lockout;
   logic [2:0] progress;
   int total = 0, bad = 0;
   bit run = 1'b0;
`ifdef BUTTON_LOCK_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif
   localparam int OPEN_N = 16, LOCK_N = 32, MAXF = 3;
   int code_sym[4] = '{2, 1, 0, 2};

   button_code_lock #(.OPEN_CYCLES(24'd16), .LOCK_CYCLES(28'd32), .MAX_FAIL(3)) dut (
      .sysclk(sysclk), .reset(reset), .b0(b0), .b1(b1), .b2(b2),
      .unlocked(unlocked), .error(error), .lockout(lockout), .progress(progress)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // model: entry as a queue of symbols, windows as remaining-cycle counts
   int pressed[$];
   int open_left = 0, lock_left = 0, fails = 0;
   bit err_now = 1'b0;
   always @(posedge sysclk) begin : model
      int n, s;
      bit ok;
      n = int'(b0) + int'(b1) + int'(b2);
      s = b0 ? 0 : b1 ? 1 : 2;
      if (reset) begin
         pressed.delete();
         open_left = 0;
         lock_left = 0;
         fails = 0;
         err_now = 1'b0;
      end else if (err_now) begin
         err_now = 1'b0;
         fails = (fails < 7) ? fails + 1 : 7;
         if (LOCK_EN && fails >= MAXF) lock_left = LOCK_N;
      end else if (open_left > 0) begin
         open_left--;
      end else if (lock_left > 0) begin
         lock_left--;
         if (lock_left == 0) fails = 0;
      end else if (n == 1) begin
         pressed.push_back(s);
         if (pressed.size() == 4) begin
            ok = 1'b1;
            foreach (pressed[i]) if (pressed[i] != code_sym[i]) ok = 1'b0;
            if (ok) begin
               open_left = OPEN_N;
               fails = 0;
            end else err_now = 1'b1;
            pressed.delete();
         end
      end
   end

   always @(negedge sysclk) if (run) begin
      check("unlocked", int'(unlocked), int'(open_left > 0));
      check("error", int'(error), int'(err_now));
      check("lockout", int'(lockout), int'(lock_left > 0));
      check("progress", int'(progress), pressed.size());
   end

   // s: 0..2 single button, 3 = b0 and b1 together
   task automatic press(input int s, input int gap);
      @(negedge sysclk);
      b0 = (s == 0) || (s == 3);
      b1 = (s == 1) || (s == 3);
      b2 = (s == 2);
      @(negedge sysclk);
      {b0, b1, b2} = 3'b000;
      repeat (gap - 1) @(negedge sysclk);
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      press(a, 5);
      press(b, 5);
      press(c, 5);
      press(d, 1);
   endtask

   task automatic window_len(input string tag, input int exp);
      int n = 0;
      repeat (OPEN_N + 8) begin
         if (unlocked) n++;
         @(negedge sysclk);
      end
      check(tag, n, exp);
   endtask

   initial begin
      repeat (3) @(negedge sysclk);
      run = 1'b1;
      reset = 1'b0;
      check("reset_progress", int'(progress), 0);
      enter(2, 1, 0, 2);
      check("open_first_cycle", int'(unlocked), 1);
      window_len("open_len", OPEN_N);
      enter(0, 1, 0, 2);
      check("err_first_cycle", int'(error), 1);
      repeat (6) @(negedge sysclk);
      press(2, 5);
      press(1, 5);
      press(3, 5);
      check("multi_ignored", int'(progress), 2);
      press(0, 5);
      press(2, 1);
      press(1, 1);
      window_len("open_len_b1", OPEN_N - 2);
      repeat (3) begin
         enter(0, 0, 0, 0);
         repeat (4) @(negedge sysclk);
      end
      repeat (LOCK_N + 4) @(negedge sysclk);
      enter(2, 1, 0, 2);
      repeat (OPEN_N + 2) @(negedge sysclk);
      enter(1, 1, 0, 2);
      repeat (4) @(negedge sysclk);
      enter(2, 1, 2, 2);
      repeat (4) @(negedge sysclk);
      enter(2, 1, 0, 2);
      repeat (OPEN_N + 2) @(negedge sysclk);
      enter(2, 2, 2, 2);
      repeat (4) @(negedge sysclk);
      check("no_lock_after_success", int'(lockout), 0);
      press(2, 3);
      press(1, 3);
      reset = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      check("reset_mid_entry", int'(progress), 0);
      enter(2, 1, 0, 2);
      check("open_after_reset", int'(unlocked), 1);
      repeat (OPEN_N + 2) @(negedge sysclk);
      repeat (5) begin
         enter(1, 0, 2, 1);
         repeat (3) @(negedge sysclk);
      end
      repeat (LOCK_N + 4) @(negedge sysclk);
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         reset = (r == 0);
         if (r < 60) {b0, b1, b2} = 3'b000;
         else if (r < 66) {b0, b1, b2} = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b011 << $urandom_range(0, 1);
         else begin
            int s;
            s = ($urandom_range(0, 3) != 0) ? code_sym[pressed.size() % 4] : $urandom_range(0, 2);
            {b0, b1, b2} = {s == 0, s == 1, s == 2};
         end
         @(negedge sysclk);
      end
      {b0, b1, b2} = 3'b000;
      reset = 1'b0;
      @(negedge sysclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
